pulse_decoder: RTL

PULSE_DECODER -- requirements
Module: pulse_decoder

---
 rtl/temporal_pkg.sv | 15 +
 rtl/edge_det.sv | 27 ++
 rtl/pulse_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/temporal_pkg.sv
// Shared types and constants for the temporal (spike-time) decoding blocks.
package temporal_pkg;

  // Default gamma window length; a result time equal to it means "no spike" (infinity).
  localparam int unsigned GammaCycleWidth = 16;
  localparam int unsigned PulseWidth      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWaitEdge,
    StMeasure,
    StDoneWin
  } state_e;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector on a single line, with a history register that can be cleared.
module edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q, prev_d;

  // Clearing the history makes a level already high on the next cycle count as an edge.
  always_comb begin
    prev_d = clr_i ? 1'b0 : d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/pulse_decoder.sv
// Decodes one pulse-width-encoded spike per gamma window into {time, fired, err}
// and presents it through a single-entry valid/ready output register.
module pulse_decoder
  import temporal_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = GammaCycleWidth,
  parameter int unsigned PULSE_WIDTH       = PulseWidth
) (
  input  logic                                   aclk,
  input  logic                                   grst_n,
  input  logic                                   gamma_start,
  input  logic                                   spike_in,
  input  logic                                   out_ready,
  output logic                                   out_valid,
  output logic [$clog2(GAMMA_CYCLE_WIDTH+1)-1:0] out_time,
  output logic                                   out_fired,
  output logic                                   out_err,
  output logic                                   overrun
);

  localparam int unsigned TimeW  = $clog2(GAMMA_CYCLE_WIDTH + 1);
  localparam int unsigned WidthW = $clog2(PULSE_WIDTH + 2);

  localparam logic [TimeW-1:0]  TimeInf    = TimeW'(GAMMA_CYCLE_WIDTH);
  localparam logic [TimeW-1:0]  CntLast    = TimeW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [WidthW-1:0] WidthLegal = WidthW'(PULSE_WIDTH);
  localparam logic [WidthW-1:0] WidthSat   = WidthW'(PULSE_WIDTH + 1);

  state_e            state_q, state_d;
  logic [TimeW-1:0]  cnt_q, cnt_d;
  logic [TimeW-1:0]  time_q, time_d;
  logic              fired_q, fired_d;
  logic              err_q, err_d;
  logic [WidthW-1:0] width_q, width_d;

  logic              out_valid_q, out_valid_d;
  logic [TimeW-1:0]  out_time_q, out_time_d;
  logic              out_fired_q, out_fired_d;
  logic              out_err_q, out_err_d;
  logic              overrun_q, overrun_d;

  logic              rise;
  logic              active;
  logic              win_end;
  logic              res_err;

  edge_det u_edge_det (
    .clk_i  (aclk),
    .rst_ni (grst_n),
    .clr_i  (gamma_start),
    .d_i    (spike_in),
    .rise_o (rise)
  );

  assign active  = (state_q == StWaitEdge) || (state_q == StMeasure);
  assign win_end = active && (gamma_start || (cnt_q == CntLast));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    time_d  = time_q;
    fired_d = fired_q;
    err_d   = err_q;
    width_d = width_q;

    if (active && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + TimeW'(1);
    end

    case (state_q)
      StWaitEdge: begin
        if (rise) begin
          if (!fired_q) begin
            fired_d = 1'b1;
            time_d  = cnt_q;
            width_d = WidthW'(1);
            state_d = StMeasure;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StMeasure: begin
        if (spike_in) begin
          if (width_q != WidthSat) width_d = width_q + WidthW'(1);
          if (width_q >= WidthLegal) err_d = 1'b1;
        end else begin
          if (width_q != WidthLegal) err_d = 1'b1;
          state_d = StWaitEdge;
        end
      end
      StDoneWin: state_d = StIdle;
      default:   state_d = state_q;
    endcase

    // Result includes this cycle's sample; a first pulse still short at window end is an error.
    res_err = fired_d && (err_d || ((state_d == StMeasure) && (width_d < WidthLegal)));

    if (win_end) state_d = StDoneWin;

    if (gamma_start) begin
      state_d = StWaitEdge;
      cnt_d   = '0;
      time_d  = '0;
      fired_d = 1'b0;
      err_d   = 1'b0;
      width_d = '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_time_d  = out_time_q;
    out_fired_d = out_fired_q;
    out_err_d   = out_err_q;
    overrun_d   = overrun_q;

    if (win_end) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_fired_d = fired_d_final();
        out_time_d  = fired_d_final() ? time_final() : TimeInf;
        out_err_d   = res_err;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Fired/time as of the end of this cycle, before any gamma_start clear.
  function automatic logic fired_d_final();
    return fired_q || ((state_q == StWaitEdge) && rise);
  endfunction

  function automatic logic [TimeW-1:0] time_final();
    return fired_q ? time_q : cnt_q;
  endfunction

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      time_q      <= '0;
      fired_q     <= 1'b0;
      err_q       <= 1'b0;
      width_q     <= '0;
      out_valid_q <= 1'b0;
      out_time_q  <= TimeInf;
      out_fired_q <= 1'b0;
      out_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      time_q      <= time_d;
      fired_q     <= fired_d;
      err_q       <= err_d;
      width_q     <= width_d;
      out_valid_q <= out_valid_d;
      out_time_q  <= out_time_d;
      out_fired_q <= out_fired_d;
      out_err_q   <= out_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_time  = out_time_q;
  assign out_fired = out_fired_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;

endmodule
